// File: rtl/fpdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpdiv_ctrl
//  Purpose  : Moore control FSM sequencing a Goldschmidt divider datapath.
//             It steers the multiplier operand muxes, drives the rega/regb
//             load enables, runs ITERS refinement passes and captures the
//             final quotient.
//  Revision : 1.0  initial release
// ============================================================================
module fpdiv_ctrl #(
  parameter int ITERS = 3            // refinement passes, legal range 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] rega_in,
  output logic        sel_mux2,
  output logic [1:0]  sel_mux4,
  output logic        en_a,
  output logic        en_b,
  output logic        busy,
  output logic        done,
  output logic [26:0] quotient,
  output logic [2:0]  iter_cnt
);

  localparam logic [2:0] c_iters = 3'(ITERS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_N = 3'd1,
    S_INIT_D = 3'd2,
    S_ITER_N = 3'd3,
    S_ITER_D = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_iter_cnt;
  logic [2:0]  w_cnt_inc;
  logic        r_done;
  logic [26:0] r_quot;

  // Pass count after the ITER_N currently executing completes.
  assign w_cnt_inc = r_iter_cnt + 3'd1;

  // State register; reset always returns to IDLE, aborting any operation.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and Moore output decode. The numerator step (en_a)
  // always precedes the denominator step (en_b), so rega is refined with
  // the old regc before regc is overwritten.
  always_comb begin
    w_next   = r_state;
    sel_mux2 = 1'b0;
    sel_mux4 = 2'b00;
    en_a     = 1'b0;
    en_b     = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_INIT_N;
      end
      S_INIT_N: begin
        en_a   = 1'b1;
        w_next = S_INIT_D;
      end
      S_INIT_D: begin
        sel_mux4 = 2'b01;
        en_b     = 1'b1;
        w_next   = S_ITER_N;
      end
      S_ITER_N: begin
        sel_mux2 = 1'b1;
        sel_mux4 = 2'b10;
        en_a     = 1'b1;
        w_next   = (w_cnt_inc == c_iters) ? S_DONE : S_ITER_D;
      end
      S_ITER_D: begin
        sel_mux2 = 1'b1;
        sel_mux4 = 2'b11;
        en_b     = 1'b1;
        w_next   = S_ITER_N;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Pass counter: cleared entering the first pass, bumped leaving each
  // ITER_N, otherwise held so the last count stays visible for debug.
  always_ff @(posedge clk) begin
    if (reset)                      r_iter_cnt <= 3'd0;
    else if (r_state == S_INIT_D)   r_iter_cnt <= 3'd0;
    else if (r_state == S_ITER_N)   r_iter_cnt <= w_cnt_inc;
  end

  // Result capture on the edge ending DONE, with a one-cycle done pulse
  // marking the first cycle the new quotient is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_quot <= 27'd0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) r_quot <= rega_in;
    end
  end

  assign done     = r_done;
  assign quotient = r_quot;
  assign iter_cnt = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpdiv_ctrl
//  Purpose  : Self-checking bench for fpdiv_ctrl (ITERS=3 and ITERS=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpdiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [26:0] rega_in;

  // outputs, index 0 = ITERS 3, index 1 = ITERS 1
  logic        sel_mux2 [2];
  logic [1:0]  sel_mux4 [2];
  logic        en_a     [2];
  logic        en_b     [2];
  logic        busy     [2];
  logic        done     [2];
  logic [26:0] quotient [2];
  logic [2:0]  iter_cnt [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  fpdiv_ctrl #(.ITERS(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .rega_in(rega_in),
    .sel_mux2(sel_mux2[0]), .sel_mux4(sel_mux4[0]), .en_a(en_a[0]),
    .en_b(en_b[0]), .busy(busy[0]), .done(done[0]),
    .quotient(quotient[0]), .iter_cnt(iter_cnt[0])
  );

  fpdiv_ctrl #(.ITERS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .rega_in(rega_in),
    .sel_mux2(sel_mux2[1]), .sel_mux4(sel_mux4[1]), .en_a(en_a[1]),
    .en_b(en_b[1]), .busy(busy[1]), .done(done[1]),
    .quotient(quotient[1]), .iter_cnt(iter_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k = cycles elapsed since start was accepted (0 = idle).
  // An operation of N passes lasts 2+2N cycles: INIT_N, INIT_D, then
  // alternating ITER_N/ITER_D, with the last slot being DONE.
  int          m_k   [2];
  logic        m_done[2];
  logic [26:0] m_q   [2];
  logic [2:0]  m_cnt [2];

  function automatic int iters_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // {sel_mux2, sel_mux4, en_a, en_b, busy}
  function automatic logic [5:0] exp_ctl(input int k, input int it);
    if (k == 0)           return 6'b0_00_0_0_0;
    if (k == 1)           return 6'b0_00_1_0_1;
    if (k == 2)           return 6'b0_01_0_1_1;
    if (k == 2 + 2 * it)  return 6'b0_00_0_0_1;
    if (k % 2 == 1)       return 6'b1_10_1_0_1;
    return 6'b1_11_0_1_1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nk;
      int last;
      last = 2 + 2 * iters_of(i);
      if (reset) begin
        m_k[i]    <= 0;
        m_done[i] <= 1'b0;
        m_q[i]    <= 27'd0;
        m_cnt[i]  <= 3'd0;
      end else begin
        m_done[i] <= (m_k[i] == last);
        if (m_k[i] == last) begin
          m_q[i] <= rega_in;
          nk = 0;
        end else if (m_k[i] == 0) begin
          nk = start ? 1 : 0;
        end else begin
          nk = m_k[i] + 1;
        end
        m_k[i] <= nk;
        if (nk >= 3) m_cnt[i] <= 3'((nk - 2) / 2);
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ctl%0d k=%0d", i, m_k[i]),
              {58'd0, sel_mux2[i], sel_mux4[i], en_a[i], en_b[i], busy[i]},
              {58'd0, exp_ctl(m_k[i], iters_of(i))});
        check($sformatf("done%0d", i), {63'd0, done[i]}, {63'd0, m_done[i]});
        check($sformatf("quot%0d", i), {37'd0, quotient[i]}, {37'd0, m_q[i]});
        check($sformatf("cnt%0d", i), {61'd0, iter_cnt[i]}, {61'd0, m_cnt[i]});
      end
    end
  end

  // ---------------- directed stimulus + literal pins ----------------
  logic [4:0] tbl [1:8];   // dut3 {sel_mux2, sel_mux4, en_a, en_b} at T+j

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [4:0] ctl3();
    return {sel_mux2[0], sel_mux4[0], en_a[0], en_b[0]};
  endfunction

  initial begin
    tbl[1] = 5'b0_00_1_0; tbl[2] = 5'b0_01_0_1;
    tbl[3] = 5'b1_10_1_0; tbl[4] = 5'b1_11_0_1;
    tbl[5] = 5'b1_10_1_0; tbl[6] = 5'b1_11_0_1;
    tbl[7] = 5'b1_10_1_0; tbl[8] = 5'b0_00_0_0;

    reset = 1'b1; start = 1'b1; rega_in = 27'h1234567;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    chk_en = 1'b1;
    tick();
    // reset held with start high: everything zero afterwards
    check("rst_ctl", {59'd0, ctl3()}, 64'd0);
    check("rst_busy_done", {62'd0, busy[0], done[0]}, 64'd0);
    check("rst_quot_cnt", {34'd0, quotient[0], iter_cnt[0]}, 64'd0);

    // single operation; rega_in differs each cycle so only the value
    // present in the DONE cycle may be captured
    start = 1'b1;                        // cycle T
    tick();
    start = 1'b0;
    for (int j = 1; j <= 9; j++) begin   // now in cycle T+j
      if (j <= 8) begin
        check($sformatf("seq3 T+%0d", j), {59'd0, ctl3()}, {59'd0, tbl[j]});
        check($sformatf("busy3 T+%0d", j), {63'd0, busy[0]}, 64'd1);
      end
      if (j == 4) check("dut1 done state T+4", {58'd0, sel_mux2[1], sel_mux4[1], en_a[1], en_b[1], busy[1]}, 64'h01);
      if (j == 5) begin
        check("dut1 done T+5", {63'd0, done[1]}, 64'd1);
        check("dut1 quot T+5", {37'd0, quotient[1]}, {37'd0, 27'h0AAAAAE});
      end
      rega_in = (j == 8) ? 27'h6000000 : (27'h0AAAAAA ^ 27'(j));
      tick();
    end
    // previous iteration leaves us in T+10 (j loop advanced once more);
    // the done cycle was T+9 -- verify quotient captured and done dropped
    check("quot3 after op", {37'd0, quotient[0]}, {37'd0, 27'h6000000});
    check("done3 one-shot", {63'd0, done[0]}, 64'd0);
    check("cnt3 held", {61'd0, iter_cnt[0]}, 64'd3);
    repeat (4) tick();

    // start held high through T+9: one op, relaunch on the done cycle
    start = 1'b1;                        // cycle T
    rega_in = 27'h2222222;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 8) rega_in = 27'h3333333;
      if (j == 9) begin
        check("held done T+9", {63'd0, done[0]}, 64'd1);
        check("held quot T+9", {37'd0, quotient[0]}, {37'd0, 27'h3333333});
        rega_in = 27'h4444444;
      end
      if (j == 10) begin
        check("relaunch INIT_N T+10", {59'd0, ctl3()}, {59'd0, 5'b0_00_1_0});
        check("quot held T+10", {37'd0, quotient[0]}, {37'd0, 27'h3333333});
      end
    end
    start = 1'b0;
    repeat (12) tick();

    // abort: reset during cycle T+4
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();                   // now in T+4
    reset = 1'b1;
    tick();                              // T+5
    reset = 1'b0;
    check("abort idle T+5", {58'd0, ctl3(), busy[0]}, 64'd0);
    check("abort quot T+5", {37'd0, quotient[0]}, 64'd0);
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("abort no done +%0d", j), {63'd0, done[0]}, 64'd0);
    end

    // start coincident with the done cycle of a short op on dut1
    start = 1'b1;
    repeat (14) tick();
    start = 1'b0;
    repeat (12) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter ITERS, default 3, sets the number of Goldschmidt refinement passes; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one division; sampled only in IDLE.
REQ-005 rega_in  input  27  datapath numerator register value, format 1.26.
REQ-006 sel_mux2  output  1  multiplier operand A select: 0 = initial approximation 0.75, 1 = regc.
REQ-007 sel_mux4  output  2  multiplier operand B select: 00 = num, 01 = denom, 10 = rega, 11 = regb.
REQ-008 en_a  output  1  datapath rega load enable.
REQ-009 en_b  output  1  datapath regb/regc load enable.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  single-cycle pulse; high for the one cycle in which quotient first holds a new result.
REQ-012 quotient  output  27  registered final quotient, format 1.26.
REQ-013 iter_cnt  output  3  count of completed refinement passes, for debug.

Function
REQ-014 The FSM SHALL have the states IDLE, INIT_N, INIT_D, ITER_N, ITER_D and DONE.
REQ-015 The FSM SHALL be Moore-type: sel_mux2, sel_mux4, en_a and en_b are decoded from the state only.
REQ-016 Per-state decode (sel_mux2, sel_mux4, en_a, en_b):
- IDLE: 0, 00, 0, 0
- INIT_N: 0, 00, 1, 0
- INIT_D: 0, 01, 0, 1
- ITER_N: 1, 10, 1, 0
- ITER_D: 1, 11, 0, 1
- DONE: 0, 00, 0, 0
REQ-017 en_a and en_b SHALL never be high in the same cycle; rega is always refined before regc is overwritten.
REQ-018 IDLE -> INIT_N when start=1, otherwise remain in IDLE.
REQ-019 INIT_N -> INIT_D unconditionally; INIT_D -> ITER_N unconditionally, and iter_cnt is cleared to 0 on that transition.
REQ-020 On leaving ITER_N, iter_cnt SHALL increment; the next state is DONE if the incremented value equals ITERS, else ITER_D.
REQ-021 ITER_D -> ITER_N unconditionally, so the final pass omits ITER_D.
REQ-022 DONE -> IDLE unconditionally; quotient loads rega_in on the edge ending DONE.
REQ-023 done SHALL be high in the cycle after DONE, in which the FSM is in IDLE.
REQ-024 Latency: if start is sampled high in cycle T, DONE occupies cycle T+2+2*ITERS and done is high in cycle T+3+2*ITERS (ITERS=3: DONE at T+8, done at T+9).
REQ-025 start while busy=1 SHALL be ignored, with no queuing or restart.
REQ-026 start during the done cycle SHALL be accepted as a new operation; quotient holds its value until the next DONE.
REQ-027 iter_cnt SHALL hold its value in IDLE and DONE.

Reset
REQ-028 Reset dominates all other inputs and takes effect on the next edge, whatever the current state.
REQ-029 Reset values: state IDLE; sel_mux2=0; sel_mux4=00; en_a=0; en_b=0; busy=0; done=0; quotient=0; iter_cnt=0.
REQ-030 Reset mid-operation SHALL abort the operation without a done pulse and without loading quotient.

Verification
REQ-031 Hold reset=1 for 2 cycles with start=1 -> all outputs 0 and busy=0 for the following cycle.
REQ-032 ITERS=3, start pulse at T -> (sel_mux2, sel_mux4, en_a, en_b) matches REQ-016, and busy, quotient and done follow REQ-022..REQ-024:
- T+1: 0, 00, 1, 0 (INIT_N)
- T+2: 0, 01, 0, 1 (INIT_D)
- T+3: 1, 10, 1, 0 (ITER_N)
- T+4: 1, 11, 0, 1 (ITER_D)
- T+5: 1, 10, 1, 0 (ITER_N)
- T+6: 1, 11, 0, 1 (ITER_D)
- T+7: 1, 10, 1, 0 (ITER_N)
- T+8: 0, 00, 0, 0 (DONE)
- busy=1 from T+1 through T+8
- quotient=rega_in(T+8) and done=1 at T+9
REQ-033 ITERS=1, start at T -> states INIT_N, INIT_D, ITER_N, DONE in T+1..T+4; done=1 at T+5; no ITER_D is entered.
REQ-034 start held high continuously from T+1 to T+8 -> exactly one operation; start at T+9 launches a second operation with INIT_N at T+10.
REQ-035 Reset asserted in cycle T+4 of an operation -> IDLE at T+5; no done pulse; quotient keeps its reset value 0.
REQ-036 Integrated with the divider datapath, ITERS=3, N=1.5 (fraction 0x400000), D=1.0 -> quotient within 4 ulp of 27'h6000000.
